// File: rtl/scv_boot_pkg.sv
// Shared types and helpers for the scv boot/download controller.
// Holds the controller state encoding, the default reset hold time and the mirror-mask helper.
package scv_boot_pkg;

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StRun   = 2'd1,
    StLoad  = 2'd2,
    StWrite = 2'd3
  } boot_state_e;

  localparam int unsigned ResHoldDefault = 64;

  // Widest cart address the mask helper supports.
  localparam int unsigned MaskW = 32;

  // Every bit at or below the highest set bit of addr becomes 1.
  function automatic logic [MaskW-1:0] mask_smear(input logic [MaskW-1:0] addr);
    logic [MaskW-1:0] m;
    m = addr;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/scv_boot_ctl.sv
// Boot controller for the scv core: sequences CORE_RESB and streams a downloaded cartridge
// image into cart memory, then publishes the ROM mirror mask.
module scv_boot_ctl
  import scv_boot_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned RES_HOLD = ResHoldDefault
) (
  input  logic              CLK,
  input  logic              RESB,
  input  logic              HOST_RST,
  input  logic              DL_START,
  input  logic              DL_END,
  input  logic              DL_VALID,
  input  logic [7:0]        DL_DATA,
  output logic              DL_READY,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_DATA,
  input  logic              MEM_ACK,
  output logic              CORE_RESB,
  output logic [ADDR_W-1:0] CART_MASK,
  output logic              OVERFLOW,
  output logic              BUSY
);

  localparam int unsigned     HoldW    = $clog2(RES_HOLD);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(RES_HOLD - 1);

  boot_state_e       state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              end_pend_q, end_pend_d;

  logic              core_resb_q, core_resb_d;
  logic              dl_ready_q, dl_ready_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] cart_mask_q, cart_mask_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;

  logic              start;
  logic              finish;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    full_d     = full_q;
    end_pend_d = end_pend_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    overflow_d = overflow_q;
    start      = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      StHold: begin
        if (DL_START) begin
          start = 1'b1;
        end else if (HOST_RST) begin
          hold_d = HoldInit;
        end else if (hold_q == '0) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StRun: begin
        if (DL_START) begin
          start = 1'b1;
        end else if (HOST_RST) begin
          state_d = StHold;
          hold_d  = HoldInit;
        end
      end
      StLoad: begin
        if (DL_VALID && !full_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = DL_DATA;
          end_pend_d = DL_END;
          state_d    = StWrite;
        end else begin
          // Past the top of the address space bytes are consumed but not written.
          if (DL_VALID) overflow_d = 1'b1;
          if (DL_END) finish = 1'b1;
        end
      end
      StWrite: begin
        if (DL_END) end_pend_d = 1'b1;
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          if (addr_q == '1) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (end_pend_q || DL_END) begin
            finish = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StHold;
    endcase

    if (start) begin
      state_d    = StLoad;
      addr_d     = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
      end_pend_d = 1'b0;
    end
    if (finish) begin
      state_d = StHold;
      hold_d  = HoldInit;
    end
  end

  // Mask is derived from the post-update byte count so the final write is included.
  logic [MaskW-1:0]  smear_full;
  logic [ADDR_W-1:0] mask_new;
  logic              unused_smear;

  always_comb begin
    smear_full = mask_smear(MaskW'(addr_d - ADDR_W'(1)));
    if (full_d) begin
      mask_new = '1;
    end else if (addr_d == '0) begin
      mask_new = '0;
    end else begin
      mask_new = smear_full[ADDR_W-1:0];
    end
  end

  assign unused_smear = ^smear_full[MaskW-1:ADDR_W];

  always_comb begin
    core_resb_d = (state_d == StRun);
    dl_ready_d  = (state_d == StLoad);
    busy_d      = (state_d != StRun);
    cart_mask_d = finish ? mask_new : cart_mask_q;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q     <= StHold;
      hold_q      <= HoldInit;
      addr_q      <= '0;
      full_q      <= 1'b0;
      end_pend_q  <= 1'b0;
      core_resb_q <= 1'b0;
      dl_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cart_mask_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      full_q      <= full_d;
      end_pend_q  <= end_pend_d;
      core_resb_q <= core_resb_d;
      dl_ready_q  <= dl_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cart_mask_q <= cart_mask_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign CORE_RESB = core_resb_q;
  assign DL_READY  = dl_ready_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DATA  = mem_data_q;
  assign CART_MASK = cart_mask_q;
  assign OVERFLOW  = overflow_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_scv_boot_ctl.sv
// Bench for scv_boot_ctl: a 17-bit instance checked every cycle against a behavioural model,
// plus a 4-bit instance sharing the same stimulus for the overflow case.
`timescale 1ns/1ps
module tb_scv_boot_ctl;

  localparam int unsigned AW   = 17;
  localparam int unsigned SW   = 4;
  localparam int          HOLD = 64;
  localparam int          NB   = 1 << AW;

  logic       CLK = 1'b0;
  logic       RESB;
  logic       HOST_RST = 1'b0;
  logic       DL_START = 1'b0;
  logic       DL_END = 1'b0;
  logic       DL_VALID = 1'b0;
  logic [7:0] DL_DATA = 8'h00;

  logic          DL_READY, MEM_REQ, MEM_ACK, CORE_RESB, OVERFLOW, BUSY;
  logic [AW-1:0] MEM_ADDR, CART_MASK;
  logic [7:0]    MEM_DATA;

  logic          s_ready, s_req, s_ack, s_core, s_ovf, s_busy;
  logic [SW-1:0] s_addr, s_mask;
  logic [7:0]    s_data;

  int ack_mode = 0;  // 0: same-cycle ack, 1: ack 7 cycles late, 2: never
  int req_age = 0;
  int cyc = 0;
  int wr_big = 0;
  int wr_small = 0;

  assign MEM_ACK = MEM_REQ && ((ack_mode == 0) || (ack_mode == 1 && req_age == 7));
  assign s_ack   = s_req;

  always #5 CLK = ~CLK;

  scv_boot_ctl #(.ADDR_W(AW), .RES_HOLD(HOLD)) u_dut (
    .CLK(CLK), .RESB(RESB), .HOST_RST(HOST_RST), .DL_START(DL_START), .DL_END(DL_END),
    .DL_VALID(DL_VALID), .DL_DATA(DL_DATA), .DL_READY(DL_READY), .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK), .CORE_RESB(CORE_RESB),
    .CART_MASK(CART_MASK), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  scv_boot_ctl #(.ADDR_W(SW), .RES_HOLD(HOLD)) u_small (
    .CLK(CLK), .RESB(RESB), .HOST_RST(HOST_RST), .DL_START(DL_START), .DL_END(DL_END),
    .DL_VALID(DL_VALID), .DL_DATA(DL_DATA), .DL_READY(s_ready), .MEM_REQ(s_req),
    .MEM_ADDR(s_addr), .MEM_DATA(s_data), .MEM_ACK(s_ack), .CORE_RESB(s_core),
    .CART_MASK(s_mask), .OVERFLOW(s_ovf), .BUSY(s_busy)
  );

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    req_age  <= MEM_REQ ? req_age + 1 : 0;
    wr_big   <= wr_big + ((MEM_REQ && MEM_ACK) ? 1 : 0);
    wr_small <= wr_small + ((s_req && s_ack) ? 1 : 0);
  end

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Smallest power of two covering n bytes, minus one; saturates at the full address space.
  function automatic logic [AW-1:0] mask_of(input int n);
    longint p;
    if (n == 0) return '0;
    p = 1;
    while (p < n) p = p * 2;
    return AW'(p - 1);
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) + (i >> 8) + 5);
  endfunction

  // Behavioural model: core running / download in progress / write outstanding,
  // cycles of reset hold remaining, and bytes written so far.
  bit            m_run, m_dl, m_wr, m_pend, m_ovf;
  int            m_hold, m_bytes;
  logic [AW-1:0] m_addr, m_mask;
  logic [7:0]    m_data;
  bit            i_host, i_start, i_end, i_valid, i_ack;
  logic [7:0]    i_data;

  always @(posedge CLK or negedge RESB) begin : model
    bit run, dl, wr, pend, ovf, fin;
    int hold, bytes;
    logic [AW-1:0] addr, mask;
    logic [7:0] data;
    if (!RESB) begin
      m_run <= 1'b0; m_dl <= 1'b0; m_wr <= 1'b0; m_pend <= 1'b0; m_ovf <= 1'b0;
      m_hold <= HOLD; m_bytes <= 0; m_addr <= '0; m_mask <= '0; m_data <= '0;
    end else begin
      run = m_run; dl = m_dl; wr = m_wr; pend = m_pend; ovf = m_ovf;
      hold = m_hold; bytes = m_bytes; addr = m_addr; mask = m_mask; data = m_data;
      fin = 1'b0;
      if (dl) begin
        if (wr) begin
          if (i_end) pend = 1'b1;
          if (i_ack) begin
            wr = 1'b0;
            bytes++;
            if (pend) fin = 1'b1;
          end
        end else if (i_valid && bytes < NB) begin
          wr = 1'b1; addr = AW'(bytes); data = i_data; pend = i_end;
        end else begin
          if (i_valid) ovf = 1'b1;
          if (i_end) fin = 1'b1;
        end
        if (fin) begin
          dl = 1'b0; mask = mask_of(bytes); hold = HOLD;
        end
      end else if (i_start) begin
        dl = 1'b1; wr = 1'b0; bytes = 0; ovf = 1'b0; pend = 1'b0; run = 1'b0;
      end else if (run) begin
        if (i_host) begin
          run = 1'b0; hold = HOLD;
        end
      end else if (i_host) begin
        hold = HOLD;
      end else begin
        hold--;
        if (hold == 0) run = 1'b1;
      end
      m_run <= run; m_dl <= dl; m_wr <= wr; m_pend <= pend; m_ovf <= ovf;
      m_hold <= hold; m_bytes <= bytes; m_addr <= addr; m_mask <= mask; m_data <= data;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_cmp",
            64'({CORE_RESB, DL_READY, MEM_REQ, MEM_ADDR, MEM_DATA, CART_MASK, OVERFLOW, BUSY}),
            64'({m_run, m_dl && !m_wr, m_wr, m_addr, m_data, m_mask, m_ovf, !m_run}));
    end
    i_host  <= HOST_RST;
    i_start <= DL_START;
    i_end   <= DL_END;
    i_valid <= DL_VALID;
    i_data  <= DL_DATA;
    i_ack   <= MEM_ACK;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int last_acc = -1;
  int gap_bad = 0;
  bit track_gap = 1'b0;

  task automatic wait_ready();
    int t = 0;
    while (!DL_READY && t < 40) begin
      tick();
      t++;
    end
    if (!DL_READY) check("ready_timeout", 64'(DL_READY), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit with_end);
    wait_ready();
    DL_VALID = 1'b1; DL_DATA = d; DL_END = with_end;
    tick();
    if (track_gap && last_acc >= 0 && (cyc - last_acc) != 2) gap_bad++;
    last_acc = cyc;
    DL_VALID = 1'b0; DL_END = 1'b0;
  endtask

  task automatic pulse_start();
    DL_START = 1'b1;
    tick();
    DL_START = 1'b0;
  endtask

  task automatic pulse_end();
    wait_ready();
    DL_END = 1'b1;
    tick();
    DL_END = 1'b0;
  endtask

  int base;
  int t;

  initial begin
    RESB = 1'b1;
    #2 RESB = 1'b0;
    chk_en = 1'b1;

    // Power-on
    tick(10);
    check("rst_core", 64'(CORE_RESB), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd1);
    check("rst_ready", 64'(DL_READY), 64'd0);
    check("rst_mask", 64'(CART_MASK), 64'd0);
    RESB = 1'b1;
    tick(63);
    check("por_core_63", 64'(CORE_RESB), 64'd0);
    tick();
    check("por_core_64", 64'(CORE_RESB), 64'd1);
    check("por_busy_64", 64'(BUSY), 64'd0);

    // Host reset for 5 cycles
    HOST_RST = 1'b1;
    tick();
    check("host_core_low", 64'(CORE_RESB), 64'd0);
    tick(4);
    HOST_RST = 1'b0;
    tick(63);
    check("host_core_63", 64'(CORE_RESB), 64'd0);
    tick();
    check("host_core_64", 64'(CORE_RESB), 64'd1);

    // 8 KiB image, same-cycle ack
    pulse_start();
    check("load_core", 64'(CORE_RESB), 64'd0);
    check("load_ready", 64'(DL_READY), 64'd1);
    base = wr_big;
    track_gap = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      send_byte(pat(i), 1'b0);
      if (i == 0) begin
        check("first_req", 64'(MEM_REQ), 64'd1);
        check("first_addr", 64'(MEM_ADDR), 64'd0);
      end
    end
    track_gap = 1'b0;
    pulse_end();
    check("img8k_writes", 64'(wr_big - base), 64'd8192);
    check("img8k_gap", 64'(gap_bad), 64'd0);
    check("img8k_mask", 64'(CART_MASK), 64'h1FFF);
    check("img8k_last_addr", 64'(MEM_ADDR), 64'h1FFF);
    check("img8k_last_data", 64'(MEM_DATA), 64'(pat(8191)));
    tick(70);
    check("img8k_run", 64'(CORE_RESB), 64'd1);

    // 3000-byte image; HOST_RST raised mid-download is deferred until it ends
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000) HOST_RST = 1'b1;
      send_byte(pat(i + 3), 1'b0);
    end
    pulse_end();
    check("img3k_mask", 64'(CART_MASK), 64'h0FFF);
    tick(10);
    check("img3k_held", 64'(CORE_RESB), 64'd0);
    HOST_RST = 1'b0;
    tick(63);
    check("img3k_core_63", 64'(CORE_RESB), 64'd0);
    tick();
    check("img3k_core_64", 64'(CORE_RESB), 64'd1);

    // Slow ack, DL_END coincident with the last byte
    ack_mode = 1;
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(pat(i + 100), i == 4);
    check("slow_req", 64'(MEM_REQ), 64'd1);
    check("slow_addr", 64'(MEM_ADDR), 64'd4);
    check("slow_data", 64'(MEM_DATA), 64'(pat(104)));
    tick(3);
    check("slow_addr_hold", 64'(MEM_ADDR), 64'd4);
    check("slow_data_hold", 64'(MEM_DATA), 64'(pat(104)));
    t = 0;
    while (MEM_REQ && t < 20) begin
      tick();
      t++;
    end
    check("slow_ack_seen", 64'(MEM_REQ), 64'd0);
    check("slow_hold_busy", 64'(BUSY), 64'd1);
    check("slow_mask", 64'(CART_MASK), 64'h7);
    tick(63);
    check("slow_core_63", 64'(CORE_RESB), 64'd0);
    tick();
    check("slow_core_64", 64'(CORE_RESB), 64'd1);
    ack_mode = 0;

    // Overflow on the 4-bit instance
    base = wr_small;
    pulse_start();
    for (int i = 0; i < 20; i++) send_byte(pat(i), 1'b0);
    check("ovf_small_ready", 64'(s_ready), 64'd1);
    pulse_end();
    check("ovf_small_writes", 64'(wr_small - base), 64'd16);
    check("ovf_small_flag", 64'(s_ovf), 64'd1);
    check("ovf_small_mask", 64'(s_mask), 64'hF);
    check("ovf_small_addr", 64'(s_addr), 64'hF);
    check("ovf_small_data", 64'(s_data), 64'(pat(15)));
    check("ovf_small_core", 64'(s_core), 64'd0);
    check("ovf_big_flag", 64'(OVERFLOW), 64'd0);
    check("ovf_big_mask", 64'(CART_MASK), 64'h1F);

    // Zero-byte download clears OVERFLOW and leaves a zero mask
    pulse_start();
    check("zero_ovf_clear", 64'(s_ovf), 64'd0);
    check("zero_small_busy", 64'(s_busy), 64'd1);
    pulse_end();
    check("zero_mask", 64'(CART_MASK), 64'd0);
    check("zero_small_mask", 64'(s_mask), 64'd0);

    // Asynchronous reset while a write is outstanding
    ack_mode = 2;
    tick(5);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    check("ares_req_up", 64'(MEM_REQ), 64'd1);
    tick(2);
    check("ares_req_wait", 64'(MEM_REQ), 64'd1);
    #1 RESB = 1'b0;
    #1;
    check("ares_req", 64'(MEM_REQ), 64'd0);
    check("ares_addr", 64'(MEM_ADDR), 64'd0);
    check("ares_data", 64'(MEM_DATA), 64'd0);
    check("ares_core", 64'(CORE_RESB), 64'd0);
    check("ares_busy", 64'(BUSY), 64'd1);
    check("ares_ready", 64'(DL_READY), 64'd0);
    ack_mode = 0;
    tick(3);
    RESB = 1'b1;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scv_boot_ctl.md
Name: scv_boot_ctl

Overview:
- Upstream of the scv top. Sequences its RESB and loads cartridge images from the host download stream into cart memory.
- Holds the core in reset at power-up, on host reset request, and for the whole duration of a download.
- Reports the cart address mask the scv top uses for ROM mirroring.

Parameters:
ADDR_W, 17, cart memory address width (128 KiB max image)
RES_HOLD, 64, CLK cycles CORE_RESB stays low after any reset cause ends (~2.2 us at 28.6 MHz); must be >= 2

Ports:
CLK  in  1  core clock (2 x 14.318181 MHz)
RESB  in  1  asynchronous active-low reset
HOST_RST  in  1  level reset request from frontend
DL_START  in  1  one-cycle pulse: begin image download
DL_END  in  1  one-cycle pulse: image complete
DL_VALID  in  1  download byte valid
DL_DATA  in  8  download byte
DL_READY  out  1  block accepts byte when DL_VALID&DL_READY
MEM_REQ  out  1  cart memory write request
MEM_ADDR  out  ADDR_W  write address
MEM_DATA  out  8  write data
MEM_ACK  in  1  one-cycle write acknowledge; may arrive in the first MEM_REQ cycle
CORE_RESB  out  1  active-low reset to scv top
CART_MASK  out  ADDR_W  image mirror mask
OVERFLOW  out  1  sticky: image exceeded 2^ADDR_W bytes
BUSY  out  1  high in every state except RUN

Behaviour:
- Clock and reset: one clock CLK. RESB is asynchronous, active-low.
- Outputs while RESB low and after its release:
  - CORE_RESB=0, DL_READY=0, MEM_REQ=0, MEM_ADDR=0, MEM_DATA=0, CART_MASK=0, OVERFLOW=0, BUSY=1.
  - State HOLD, hold counter = RES_HOLD-1.
- RESB asserted mid-write drops MEM_REQ immediately; the partial image is abandoned.
- All outputs are registered.
- States: HOLD, RUN, LOAD, WRITE.
- HOLD:
  - CORE_RESB=0.
  - Counter decrements each cycle. HOST_RST=1 reloads it to RES_HOLD-1 and freezes it.
  - Counter==0 and HOST_RST=0 -> RUN.
  - DL_START -> LOAD, with priority over all other HOLD events.
- RUN:
  - CORE_RESB=1.
  - HOST_RST -> HOLD with counter reloaded.
  - DL_START -> LOAD; DL_START wins if both are asserted.
- Entering LOAD from DL_START: address counter=0, byte count=0, OVERFLOW=0, end_pend=0.
- LOAD:
  - CORE_RESB=0, DL_READY=1.
  - On DL_VALID: latch DL_DATA to MEM_DATA and address to MEM_ADDR, MEM_REQ=1, DL_READY=0 -> WRITE.
  - DL_END with no byte -> HOLD, computing CART_MASK, counter reloaded.
  - DL_END in the same cycle as an accepted byte sets end_pend.
- WRITE:
  - MEM_REQ, MEM_ADDR and MEM_DATA held stable until MEM_ACK.
  - On MEM_ACK: MEM_REQ=0 next cycle, address+1, count+1. Then -> LOAD, or -> HOLD (with mask update) if end_pend.
  - DL_END arriving during WRITE sets end_pend.
- Throughput with same-cycle ack: byte accepted at cycle n, MEM_REQ high at n+1, DL_READY high again at n+2.
- Overflow:
  - After the byte at address 2^ADDR_W-1 is written, the count saturates.
  - Further accepted bytes are dropped: no MEM_REQ, OVERFLOW=1, stays in LOAD.
- CART_MASK:
  - last = count-1.
  - Mask = bit-smear of last: every bit at or below its highest set bit becomes 1.
  - count 0 -> mask 0. Overflow -> all ones.
  - Updated only on the transition to HOLD at end of download.
- Ignored events:
  - DL_START during LOAD or WRITE.
  - HOST_RST during LOAD or WRITE; the download completes first. If HOST_RST is still high in HOLD, it then holds the core there.
- DL_VALID outside LOAD: ignored, DL_READY=0.

Decomposition:
- Package scv_boot_pkg:
  - state enum (HOLD, RUN, LOAD, WRITE);
  - default RES_HOLD constant;
  - function mask_smear(addr) returning the ADDR_W-bit smeared mask.
- No sub-module. The hold counter and address counter are plain registers in scv_boot_ctl.

Test Plan:
- Power-on: RESB low 10 cycles then high, HOST_RST=0 -> CORE_RESB rises exactly 64 CLK after RESB release, BUSY falls the same cycle.
- Host reset: in RUN, HOST_RST high 5 cycles -> CORE_RESB low the cycle after assertion, high 64 cycles after deassertion.
- 8 KiB image: DL_START, 0x2000 bytes with MEM_ACK in the same cycle as MEM_REQ, then DL_END:
  - writes land at 0x0000..0x1FFF with matching data;
  - DL_READY period is 2 cycles;
  - CART_MASK=0x01FFF.
  - Repeat with 3000 bytes -> CART_MASK=0x00FFF.
- Ack latency and end: MEM_ACK delayed 7 cycles, DL_END coincident with the last byte -> MEM_ADDR and MEM_DATA stable through the wait; HOLD entered after the final ack; CORE_RESB high 64 cycles later.
- Overflow with ADDR_W=4: send 20 bytes -> 16 MEM_REQ pulses only, OVERFLOW=1, CART_MASK=0xF. A new DL_START clears OVERFLOW.
- Async reset mid-write:
  - RESB low while MEM_REQ=1 and no ack -> MEM_REQ=0 immediately, all outputs at reset values.
  - Zero-byte download (DL_START, then DL_END) -> CART_MASK=0.
